peri_timer: RTL and testbench
=============================

Name: peri_timer

Overview:
- Memory-mapped 8-bit timer/counter.
- Acts as a responder on the TRSQ8 peripheral bus (addr, data, wr_en, rd_en) driven by the CPU core.
- Provides prescaled up-counting, a period match, one-shot or auto-reload modes, and a level interrupt request suitable for the CPU irq_ip input.
- Read data is zero when the block is not selected, so outputs of several peripherals can be OR-combined.

Parameters:
- BASE_ADDR, 8'h10: base of the 4-register window; must be 4-aligned. Hit when addr_ip[7:2] == BASE_ADDR[7:2].
- RESET_PERIOD, 8'hFF: reset value of the PERIOD register.

Ports:
- clk_ip  in  1  system clock; all state updates on its rising edge.
- reset_ip  in  1  reset, synchronous, active-high.
- addr_ip  in  8  peripheral bus address from CPU.
- data_ip  in  8  write data from CPU (W register).
- data_op  out  8  read data to CPU; combinational.
- wr_en_ip  in  1  write strobe; sampled at rising edge.
- rd_en_ip  in  1  read strobe.
- irq_op  out  1  interrupt request, level = STATUS.OVF & CTRL.IRQ_EN.

Behaviour:
- Register map (offset = addr_ip[1:0]):
  - 0 CTRL, RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits5:3 PRESCALE n, bits7:6 read 0.
  - 1 STATUS: bit0 OVF, sticky, write-1-to-clear; bit1 RUNNING (=EN), read-only; other bits read 0.
  - 2 COUNT, RW.
  - 3 PERIOD, RW.
- Reset values: CTRL=0, STATUS.OVF=0, COUNT=0, PERIOD=RESET_PERIOD, prescaler=0. data_op=0 and irq_op=0 during and after reset.
- Reads:
  - data_op = selected register when hit & rd_en_ip, else 8'h00.
  - Zero latency, so the CPU latches the value at the same edge.
  - Reads have no side effects.
- Writes: captured at the rising edge when hit & wr_en_ip. If rd_en_ip and wr_en_ip are both high, the write still takes effect.
- Prescaler:
  - 7-bit counter, active only while EN=1.
  - tick = (prescaler == 2^n − 1); the prescaler wraps to 0 on tick.
  - n=0 gives a tick every clock. n=7 gives a tick every 128 clocks.
- Counter, on tick:
  - If COUNT == PERIOD: COUNT<=0, OVF<=1. If AUTO_RELOAD=0, EN<=0 (one-shot stop).
  - Else COUNT<=COUNT+1 (8-bit).
- Enable edge:
  - A write setting EN from 0→1 clears the prescaler.
  - The first tick can occur at the first edge after the write edge.
  - Example: PERIOD=P gives OVF set at edge (P+1)·2^n after the enabling write.
- Disable: writing EN=0 freezes COUNT, clears the prescaler, and leaves OVF unchanged.
- PERIOD=0: every tick sets OVF, and COUNT stays 0.
- Simultaneous events:
  - COUNT write and tick in the same cycle → the written value wins.
  - OVF W1C and OVF set in the same cycle → set wins (OVF stays 1).
  - CTRL write and one-shot auto-clear of EN in the same cycle → the written CTRL wins.
  - PERIOD write during counting → the new value is used from the next cycle. If COUNT is already above the new PERIOD, the counter runs to 8'hFF, wraps to 0 without setting OVF, and continues.
- Reset mid-count: all state returns to reset values at that edge, and irq_op drops in the next cycle.
- Addresses outside the window: ignored; data_op=0.

Decomposition:
- Shared package/include trsq8_peri_pkg holds:
  - Register offsets: TMR_CTRL=0, TMR_STATUS=1, TMR_COUNT=2, TMR_PERIOD=3.
  - CTRL/STATUS bit positions.
  - Bus widths ADDR_W=8, DATA_W=8.
- One sub-module, timer_prescaler: inputs clk, reset, enable, clear, n[2:0]; output tick.
- Register file, counter and IRQ logic stay in peri_timer.

Test Plan:
- Reset, then read all four offsets at BASE_ADDR → 00, 00, 00, FF. Read at BASE_ADDR+4 → 00. irq_op=0.
- Write PERIOD=3, then CTRL=8'h07 (EN, AUTO_RELOAD, IRQ_EN, n=0) → COUNT reads 1, 2, 3, 0 on successive cycles; OVF=1 and irq_op=1 exactly 4 edges after the CTRL write; counting continues.
- One-shot: PERIOD=1, CTRL=8'h09 (EN, n=1) → OVF set at edge 4; EN and RUNNING read 0 afterwards; COUNT frozen at 0; irq_op stays 0 (IRQ_EN=0).
- W1C race: arrange a STATUS write of 8'h01 on the same edge as an overflow → OVF remains 1. A later STATUS write of 8'h01 with no tick → OVF=0 and irq_op=0 the next cycle.
- COUNT write collision: while counting with n=0, write COUNT=8'h50 → the next read returns 8'h50, not the incremented value. Then write PERIOD=8'h10 → COUNT wraps through 8'hFF to 8'h00 with no OVF.
- Assert reset_ip mid-count with n=3 → the next edge gives COUNT=0, CTRL=0, OVF=0, irq_op=0, PERIOD=FF. Re-enabling restarts the prescaler from 0.

Source files
------------

// File: rtl/trsq8_peri_pkg.sv
// Shared definitions for TRSQ8 peripheral-bus responders: bus widths,
// timer register offsets and CTRL/STATUS bit positions.
package trsq8_peri_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned PRE_W      = 7;
    localparam int unsigned PRESCALE_W = 3;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_STATUS = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_PERIOD = 2'd3;

    localparam int unsigned CTRL_EN_BIT        = 0;
    localparam int unsigned CTRL_AR_BIT        = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT    = 2;
    localparam int unsigned CTRL_PRESCALE_LSB  = 3;
    localparam int unsigned STATUS_OVF_BIT     = 0;
    localparam int unsigned STATUS_RUNNING_BIT = 1;

    // CTRL register image; field order matches the bit layout so it reads back directly.
    typedef struct packed {
        logic [1:0]            rsvd;
        logic [PRESCALE_W-1:0] prescale;
        logic                  irq_en;
        logic                  auto_reload;
        logic                  en;
    } tmr_ctrl_t;

    // Terminal prescaler value for a divide-by-2^n tick.
    function automatic logic [PRE_W-1:0] prescale_last(input logic [PRESCALE_W-1:0] n);
        return PRE_W'((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running 7-bit prescaler: emits a one-cycle tick every 2^n clocks
// while enabled, and is held at zero while disabled or cleared.
module timer_prescaler
    import trsq8_peri_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [PRESCALE_W-1:0] n_i,
    output logic                  tick_c_o
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign tick_c_o = enable_i && (pre_q == prescale_last(n_i));

    // A smaller n may leave pre_q above the terminal value; it then wraps at 127.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (!enable_i || clear_i || tick_c_o) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/peri_timer.sv
// Memory-mapped 8-bit timer on the TRSQ8 peripheral bus: prescaled up-count,
// period match, one-shot / auto-reload, sticky OVF and level interrupt.
module peri_timer
    import trsq8_peri_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 8'h10,
    parameter logic [DATA_W-1:0] RESET_PERIOD = 8'hFF
) (
    input  logic              clk_ip,
    input  logic              reset_ip,
    input  logic [ADDR_W-1:0] addr_ip,
    input  logic [DATA_W-1:0] data_ip,
    output logic [DATA_W-1:0] data_op,
    input  logic              wr_en_ip,
    input  logic              rd_en_ip,
    output logic              irq_op
);

    localparam logic [ADDR_W-3:0] BASE_HI = BASE_ADDR[ADDR_W-1:2];

    tmr_ctrl_t         ctrl_q;
    tmr_ctrl_t         ctrl_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] count_d;
    logic [DATA_W-1:0] period_q;
    logic [DATA_W-1:0] period_d;

    logic       hit_c;
    logic [1:0] off_c;
    logic       wr_ctrl_c;
    logic       wr_status_c;
    logic       wr_count_c;
    logic       wr_period_c;
    logic       en_rise_c;
    logic       tick_c;

    assign hit_c       = (addr_ip[ADDR_W-1:2] == BASE_HI);
    assign off_c       = addr_ip[1:0];
    assign wr_ctrl_c   = hit_c && wr_en_ip && (off_c == TMR_CTRL);
    assign wr_status_c = hit_c && wr_en_ip && (off_c == TMR_STATUS);
    assign wr_count_c  = hit_c && wr_en_ip && (off_c == TMR_COUNT);
    assign wr_period_c = hit_c && wr_en_ip && (off_c == TMR_PERIOD);
    assign en_rise_c   = wr_ctrl_c && data_ip[CTRL_EN_BIT] && !ctrl_q.en;

    timer_prescaler u_prescaler (
        .clk_i    (clk_ip),
        .reset_i  (reset_ip),
        .enable_i (ctrl_q.en),
        .clear_i  (en_rise_c),
        .n_i      (ctrl_q.prescale),
        .tick_c_o (tick_c)
    );

    // Bus writes are applied last so they win over same-cycle counter events,
    // except that an OVF set beats a same-cycle write-1-to-clear.
    always_comb begin
        ctrl_d   = ctrl_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        period_d = period_q;

        if (wr_status_c && data_ip[STATUS_OVF_BIT]) begin
            ovf_d = 1'b0;
        end

        if (tick_c) begin
            if (count_q == period_q) begin
                count_d = '0;
                ovf_d   = 1'b1;
                if (!ctrl_q.auto_reload) begin
                    ctrl_d.en = 1'b0;
                end
            end else begin
                count_d = count_q + DATA_W'(1);
            end
        end

        if (wr_ctrl_c) begin
            ctrl_d             = '0;
            ctrl_d.en          = data_ip[CTRL_EN_BIT];
            ctrl_d.auto_reload = data_ip[CTRL_AR_BIT];
            ctrl_d.irq_en      = data_ip[CTRL_IRQ_EN_BIT];
            ctrl_d.prescale    = data_ip[CTRL_PRESCALE_LSB +: PRESCALE_W];
        end
        if (wr_count_c) begin
            count_d = data_ip;
        end
        if (wr_period_c) begin
            period_d = data_ip;
        end
    end

    always_ff @(posedge clk_ip) begin
        if (reset_ip) begin
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            period_q <= RESET_PERIOD;
        end else begin
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            period_q <= period_d;
        end
    end

    // Zero when not selected so several responders can be OR-combined.
    always_comb begin
        data_op = '0;
        if (hit_c && rd_en_ip && !reset_ip) begin
            unique case (off_c)
                TMR_CTRL: data_op = ctrl_q;
                TMR_STATUS: begin
                    data_op[STATUS_OVF_BIT]     = ovf_q;
                    data_op[STATUS_RUNNING_BIT] = ctrl_q.en;
                end
                TMR_COUNT:  data_op = count_q;
                TMR_PERIOD: data_op = period_q;
                default:    data_op = '0;
            endcase
        end
    end

    assign irq_op = !reset_ip && ovf_q && ctrl_q.irq_en;

endmodule

// File: tb/tb_peri_timer.sv
// Scoreboard bench for peri_timer: directed scenarios plus random bus traffic
// checked against a cycle-level behavioural model of the timer.
module tb_peri_timer;

    localparam logic [7:0] BASE   = 8'h10;
    localparam logic [7:0] A_CTRL = 8'h10;
    localparam logic [7:0] A_STAT = 8'h11;
    localparam logic [7:0] A_CNT  = 8'h12;
    localparam logic [7:0] A_PER  = 8'h13;

    logic       clk = 1'b0;
    logic       reset_ip = 1'b1;
    logic [7:0] addr_ip = 8'h00;
    logic [7:0] data_ip = 8'h00;
    logic       wr_en_ip = 1'b0;
    logic       rd_en_ip = 1'b0;
    logic [7:0] data_op;
    logic       irq_op;

    peri_timer #(.BASE_ADDR(BASE), .RESET_PERIOD(8'hFF)) dut (
        .clk_ip   (clk),
        .reset_ip (reset_ip),
        .addr_ip  (addr_ip),
        .data_ip  (data_ip),
        .data_op  (data_op),
        .wr_en_ip (wr_en_ip),
        .rd_en_ip (rd_en_ip),
        .irq_op   (irq_op)
    );

    always #5 clk = ~clk;

    // Behavioural model state (plain integers).
    int m_en = 0, m_ar = 0, m_irq = 0, m_n = 0, m_ovf = 0;
    int m_count = 0, m_period = 255, m_pre = 0;

    logic [7:0] exp_q[$];
    int         irq_q[$];
    string      name_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [7:0] a);
        return (a >= BASE) && (a <= BASE + 8'd3);
    endfunction

    function automatic logic [7:0] mread(input logic [7:0] a);
        if (reset_ip || !in_win(a)) return 8'h00;
        case (int'(a) - int'(BASE))
            0:       return 8'(m_n * 8 + m_irq * 4 + m_ar * 2 + m_en);
            1:       return 8'(m_en * 2 + m_ovf);
            2:       return 8'(m_count);
            default: return 8'(m_period);
        endcase
    endfunction

    // One rising edge of the timer, using the bus values held during the cycle.
    task automatic model_step();
        bit wr, tick, set_ovf;
        int off, next_pre;
        if (reset_ip) begin
            m_en = 0; m_ar = 0; m_irq = 0; m_n = 0; m_ovf = 0;
            m_count = 0; m_period = 255; m_pre = 0;
            return;
        end
        wr  = wr_en_ip && in_win(addr_ip);
        off = int'(addr_ip) - int'(BASE);
        tick = (m_en != 0) && (m_pre == (1 << m_n) - 1);
        if (m_en == 0 || tick) next_pre = 0;
        else next_pre = (m_pre + 1) % 128;
        if (wr && off == 0 && data_ip[0] && m_en == 0) next_pre = 0;
        set_ovf = 0;
        if (tick) begin
            if (m_count == m_period) begin
                m_count = 0;
                set_ovf = 1;
                if (m_ar == 0) m_en = 0;
            end else begin
                m_count = (m_count + 1) % 256;
            end
        end
        m_pre = next_pre;
        if (wr && off == 1 && data_ip[0]) m_ovf = 0;
        if (set_ovf) m_ovf = 1;
        if (wr && off == 0) begin
            m_en  = int'(data_ip[0]);
            m_ar  = int'(data_ip[1]);
            m_irq = int'(data_ip[2]);
            m_n   = int'(data_ip[5:3]);
        end
        if (wr && off == 2) m_count  = int'(data_ip);
        if (wr && off == 3) m_period = int'(data_ip);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic push(input logic [7:0] e, input int ei, input string nm);
        exp_q.push_back(e);
        irq_q.push_back(ei);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            wr_en_ip = 1'b0;
            rd_en_ip = 1'b0;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step();
        addr_ip = a; data_ip = d; wr_en_ip = 1'b1; rd_en_ip = 1'b0;
    endtask

    // Directed read with a fixed expectation; ei < 0 skips the irq check.
    task automatic rd(input logic [7:0] a, input logic [7:0] e, input int ei, input string nm);
        step();
        addr_ip = a; wr_en_ip = 1'b0; rd_en_ip = 1'b1;
        push(e, ei, nm);
    endtask

    task automatic rdm(input logic [7:0] a, input string nm);
        step();
        addr_ip = a; wr_en_ip = 1'b0; rd_en_ip = 1'b1;
        push(mread(a), -1, nm);
    endtask

    task automatic rwm(input logic [7:0] a, input logic [7:0] d, input string nm);
        step();
        addr_ip = a; data_ip = d; wr_en_ip = 1'b1; rd_en_ip = 1'b1;
        push(mread(a), -1, nm);
    endtask

    task automatic rst_cyc(input bit v);
        step();
        reset_ip = v; wr_en_ip = 1'b0; rd_en_ip = 1'b0;
    endtask

    // Monitor: irq level every cycle, read data whenever a read is presented.
    always @(negedge clk) begin
        logic [7:0] e;
        int         ei;
        string      nm;
        check("irq_level", int'(irq_op), int'((m_ovf != 0) && (m_irq != 0) && !reset_ip));
        if (rd_en_ip) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e  = exp_q.pop_front();
                ei = irq_q.pop_front();
                nm = name_q.pop_front();
                check(nm, int'(data_op), int'(e));
                if (ei >= 0) check({nm, "_irq"}, int'(irq_op), ei);
            end
        end else begin
            check("idle_rdata_zero", int'(data_op), 0);
        end
    end

    initial begin
        logic [7:0] a, d;
        int r, off;

        // Reset state and out-of-window read.
        idle(2);
        rd(A_PER, 8'h00, 0, "rd_in_reset");
        rst_cyc(1'b0);
        rd(A_CTRL, 8'h00, 0, "rst_ctrl");
        rd(A_STAT, 8'h00, 0, "rst_status");
        rd(A_CNT,  8'h00, 0, "rst_count");
        rd(A_PER,  8'hFF, 0, "rst_period");
        rd(8'h14,  8'h00, 0, "rst_outside");

        // Auto-reload, n=0, PERIOD=3: OVF four edges after enabling write.
        wr(A_PER, 8'h03);
        wr(A_CTRL, 8'h07);
        rd(A_CNT,  8'h00, 0, "ar_cnt0");
        rd(A_CNT,  8'h01, 0, "ar_cnt1");
        rd(A_CNT,  8'h02, 0, "ar_cnt2");
        rd(A_STAT, 8'h02, 0, "ar_pre_ovf");
        rd(A_STAT, 8'h03, 1, "ar_ovf");
        rd(A_CNT,  8'h01, 1, "ar_continues");
        wr(A_CTRL, 8'h00);
        wr(A_STAT, 8'h01);
        wr(A_CNT, 8'h00);

        // One-shot, n=1, PERIOD=1.
        wr(A_PER, 8'h01);
        wr(A_CTRL, 8'h09);
        rd(A_CNT,  8'h00, 0, "os_cnt0");
        rd(A_STAT, 8'h02, 0, "os_run");
        rd(A_CNT,  8'h01, 0, "os_cnt1");
        rd(A_STAT, 8'h02, 0, "os_pre_ovf");
        rd(A_STAT, 8'h01, 0, "os_ovf_stopped");
        rd(A_CTRL, 8'h08, 0, "os_en_cleared");
        rd(A_CNT,  8'h00, 0, "os_cnt_frozen");
        idle(5);
        rd(A_CNT,  8'h00, 0, "os_cnt_still");

        // OVF write-1-to-clear racing an overflow, then a clean clear.
        wr(A_STAT, 8'h01);
        wr(A_PER, 8'h02);
        wr(A_CTRL, 8'h07);
        idle(2);
        wr(A_STAT, 8'h01);
        rd(A_STAT, 8'h03, 1, "w1c_race_set_wins");
        wr(A_CTRL, 8'h04);
        rd(A_STAT, 8'h01, 1, "w1c_stopped");
        wr(A_STAT, 8'h01);
        rd(A_STAT, 8'h00, 0, "w1c_cleared");

        // COUNT write beats tick; PERIOD drop below COUNT wraps without OVF.
        wr(A_PER, 8'hFF);
        wr(A_CTRL, 8'h05);
        idle(2);
        wr(A_CNT, 8'h50);
        rd(A_CNT, 8'h50, 0, "cnt_write_wins");
        wr(A_PER, 8'h10);
        idle(173);
        rd(A_CNT,  8'hFF, 0, "wrap_ff");
        rd(A_CNT,  8'h00, 0, "wrap_00");
        rd(A_STAT, 8'h02, 0, "wrap_no_ovf");
        idle(20);
        rd(A_STAT, 8'h01, 1, "wrap_then_match");
        rd(A_CTRL, 8'h04, 1, "wrap_oneshot_ctrl");

        // Reset mid-count with n=3, then re-enable.
        wr(A_STAT, 8'h01);
        wr(A_PER, 8'h02);
        wr(A_CTRL, 8'h1F);
        idle(28);
        rd(A_STAT, 8'h03, 1, "n3_ovf");
        rst_cyc(1'b1);
        rst_cyc(1'b0);
        rd(A_CTRL, 8'h00, 0, "mid_rst_ctrl");
        rd(A_STAT, 8'h00, 0, "mid_rst_status");
        rd(A_CNT,  8'h00, 0, "mid_rst_count");
        rd(A_PER,  8'hFF, 0, "mid_rst_period");
        wr(A_PER, 8'h05);
        wr(A_CTRL, 8'h19);
        idle(7);
        rd(A_CNT, 8'h00, 0, "reen_before_tick");
        rd(A_CNT, 8'h01, 0, "reen_first_tick");

        // Random bus traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            r   = $urandom_range(0, 99);
            off = $urandom_range(0, 3);
            a   = BASE + 8'(off);
            if ($urandom_range(0, 9) == 0) a = 8'($urandom);
            d = 8'($urandom);
            if (off == 0) begin
                if ($urandom_range(0, 3) != 0) d[5] = 1'b0;
                d[0] = ($urandom_range(0, 3) != 0);
            end
            if (off == 3 && $urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 12));
            if (r < 2) begin
                rst_cyc(1'b1);
                rst_cyc(1'b0);
            end else if (r < 25) begin
                wr(a, d);
            end else if (r < 35) begin
                rwm(a, d, "rand_rw");
            end else if (r < 75) begin
                rdm(a, "rand_rd");
            end else begin
                idle(1);
            end
        end

        idle(3);
        check("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
